// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared defaults and types for the UART FIFO controllers.
//   FIFO_AW_DEF : default register file address width (depth = 2**W)
//   AF_TH_DEF   : default almost-full threshold (level >= AF_TH)
//   AE_TH_DEF   : default almost-empty threshold (level <= AE_TH)
//   fifo_flags_t: bundle of the level-derived status flags
package fifo_ctrl_pkg;

   localparam int FIFO_AW_DEF = 3;
   localparam int AF_TH_DEF   = 6;
   localparam int AE_TH_DEF   = 1;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

endpackage

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/occupancy controller that runs a synchronous-write,
// combinational-read register file as a first-word-fall-through FIFO.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   clr            synchronous flush of pointers, level and sticky flags
//   wr, rd         push / pop requests
//   wr_en          register file write enable (accepted push)
//   w_addr, r_addr register file write / read addresses
//   full, empty    level == 2**W / level == 0
//   almost_full    level >= AF_TH
//   almost_empty   level <= AE_TH
//   level          occupancy 0..2**W
//   overflow       sticky: a push was rejected
//   underflow      sticky: a pop was rejected
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int W     = FIFO_AW_DEF,
   parameter int AF_TH = AF_TH_DEF,
   parameter int AE_TH = AE_TH_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         wr,
   input  logic         rd,
   output logic         wr_en,
   output logic [W-1:0] w_addr,
   output logic [W-1:0] r_addr,
   output logic         full,
   output logic         empty,
   output logic         almost_full,
   output logic         almost_empty,
   output logic [W:0]   level,
   output logic         overflow,
   output logic         underflow
);

   localparam logic [W:0] DEPTH = {1'b1, {W{1'b0}}};
   localparam logic [W:0] AF_L  = (W+1)'(AF_TH);
   localparam logic [W:0] AE_L  = (W+1)'(AE_TH);

   logic [W-1:0] w_ptr, r_ptr;
   logic [W:0]   lvl;
   logic         push_ok, pop_ok;
   fifo_flags_t  flags;

   // Status flags come only from the level register, never from wr/rd.
   always_comb begin
      flags              = '0;
      flags.full         = (lvl == DEPTH);
      flags.empty        = (lvl == '0);
      flags.almost_full  = (lvl >= AF_L);
      flags.almost_empty = (lvl <= AE_L);
   end

   // A push into a full FIFO is allowed when a pop frees the slot in the
   // same cycle: the write lands on the word being read out.
   assign push_ok = wr & (~flags.full | rd);
   assign pop_ok  = rd & ~flags.empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         lvl       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         lvl       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) w_ptr <= w_ptr + 1'b1;
         if (pop_ok)  r_ptr <= r_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   lvl <= lvl + 1'b1;
            2'b01:   lvl <= lvl - 1'b1;
            default: lvl <= lvl;
         endcase
         if (wr & ~push_ok) overflow  <= 1'b1;
         if (rd & ~pop_ok)  underflow <= 1'b1;
      end
   end

   assign wr_en        = push_ok & ~clr;
   assign w_addr       = w_ptr;
   assign r_addr       = r_ptr;
   assign level        = lvl;
   assign full         = flags.full;
   assign empty        = flags.empty;
   assign almost_full  = flags.almost_full;
   assign almost_empty = flags.almost_empty;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: wraps fifo_ctrl with a behavioural register file, drives
// directed then randomized push/pop/clear traffic, and checks every cycle
// against a queue-based FIFO reference model.
module tb_fifo_ctrl;

   localparam int W     = 3;
   localparam int DEPTH = 1 << W;
   localparam int AF_TH = 6;
   localparam int AE_TH = 1;

   logic         clk = 1'b0;
   logic         rst, clr, wr, rd;
   logic         wr_en;
   logic [W-1:0] w_addr, r_addr;
   logic         full, empty, almost_full, almost_empty;
   logic [W:0]   level;
   logic         overflow, underflow;
   logic [7:0]   wdata;
   logic [7:0]   mem [DEPTH];
   logic [7:0]   r_data;

   int nchk  = 0;
   int nfail = 0;

   // reference model state
   logic [7:0] q [$];
   int  m_wp = 0, m_rp = 0;
   bit  m_ovf = 0, m_udf = 0;

   fifo_ctrl #(.W(W), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
      .clk(clk), .rst(rst), .clr(clr), .wr(wr), .rd(rd),
      .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .level(level),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (wr_en) mem[w_addr] <= wdata;
   assign r_data = mem[r_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compare DUT against the model mid-cycle, then advance the model
   // with what the coming edge should commit.
   always @(negedge clk) begin
      int  lv;
      bit  push_ok, pop_ok;
      if (!rst) begin
         q.delete();
         m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
      end
      lv      = q.size();
      push_ok = wr && (lv < DEPTH || rd);
      pop_ok  = rd && lv > 0;
      chk("level",        32'(level),        32'(lv));
      chk("full",         32'(full),         32'(lv == DEPTH));
      chk("empty",        32'(empty),        32'(lv == 0));
      chk("almost_full",  32'(almost_full),  32'(lv >= AF_TH));
      chk("almost_empty", 32'(almost_empty), 32'(lv <= AE_TH));
      chk("w_addr",       32'(w_addr),       32'(m_wp));
      chk("r_addr",       32'(r_addr),       32'(m_rp));
      chk("overflow",     32'(overflow),     32'(m_ovf));
      chk("underflow",    32'(underflow),    32'(m_udf));
      chk("wr_en",        32'(wr_en),        32'(push_ok && !clr));
      if (rst && !clr && pop_ok) chk("r_data", 32'(r_data), 32'(q[0]));
      if (rst) begin
         if (clr) begin
            q.delete();
            m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
         end else begin
            if (pop_ok)  begin void'(q.pop_front()); m_rp = (m_rp + 1) % DEPTH; end
            if (push_ok) begin q.push_back(wdata);   m_wp = (m_wp + 1) % DEPTH; end
            if (wr && !push_ok) m_ovf = 1;
            if (rd && !pop_ok)  m_udf = 1;
         end
      end
   end

   task automatic step(input bit w, input bit r, input bit c, input logic [7:0] d);
      wr = w; rd = r; clr = c; wdata = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", 32'(level), 0);
      chk("rst_empty", 32'(empty), 1);
      rst = 1'b1;

      // fill to full, then one rejected push
      for (int i = 0; i < 8; i++) step(1, 0, 0, 8'(8'h11 + i));
      step(1, 0, 0, 8'hAA);
      // drain in order
      for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00);
      // pop while empty, then push+pop while empty
      step(0, 1, 0, 8'h00);
      step(1, 1, 0, 8'h55);
      step(0, 1, 0, 8'h00);
      // clear flags, fill, then push+pop while full
      step(0, 0, 1, 8'h00);
      for (int i = 0; i < 8; i++) step(1, 0, 0, 8'(8'h11 + i));
      for (int i = 0; i < 3; i++) step(1, 1, 0, 8'h99);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00);
      // fill to 5, clear together with a push
      for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h30 + i));
      step(1, 0, 1, 8'h77);
      step(0, 0, 0, 8'h00);

      // asynchronous reset mid-burst, checked before the next edge
      for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'h40 + i));
      step(0, 1, 0, 8'h00);
      rst = 1'b0;
      #1;
      chk("arst_level",  32'(level),     0);
      chk("arst_empty",  32'(empty),     1);
      chk("arst_w_addr", 32'(w_addr),    0);
      chk("arst_r_addr", 32'(r_addr),    0);
      chk("arst_udf",    32'(underflow), 0);
      wr = 1'b0; rd = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      // randomized traffic, phases biased toward filling / draining
      for (int i = 0; i < 900; i++) begin
         int ph, pw;
         ph = (i / 100) % 3;
         pw = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
         step($urandom_range(99) < pw, $urandom_range(99) < (100 - pw),
              $urandom_range(63) == 0, 8'($urandom));
      end
      step(0, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Pointer and occupancy controller that sequences the UART register file (synchronous write, combinational read) as a first-word-fall-through FIFO. It sits between the UART rx/tx datapath and the register file, and drives the register file's wr_en, w_addr and r_addr. It also reports full/empty, level, almost-full/almost-empty and sticky overflow/underflow status to the UART control logic.

Parameters:
W, 3, address width of the register file; FIFO depth = 2**W
AF_TH, 6, almost_full asserts when level >= AF_TH (range 1..2**W)
AE_TH, 1, almost_empty asserts when level <= AE_TH (range 0..2**W-1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted at 0)
clr  input  1  synchronous flush; pointers, level and sticky flags go to 0
wr  input  1  push request; data is presented to the register file by the requester
rd  input  1  pop request; consumes the word currently on the register file r_data
wr_en  output  1  register file write enable (accepted push)
w_addr  output  W  register file write address (write pointer)
r_addr  output  W  register file read address (read pointer)
full  output  1  level == 2**W
empty  output  1  level == 0
almost_full  output  1  level >= AF_TH
almost_empty  output  1  level <= AE_TH
level  output  W+1  current occupancy, 0..2**W
overflow  output  1  sticky: a push was rejected
underflow  output  1  sticky: a pop was rejected

Behaviour:
- Reset (rst=0, asynchronous): w_ptr=0, r_ptr=0, level=0, overflow=0, underflow=0. Resulting outputs: empty=1, full=0, almost_empty=1 (since AE_TH>=0), almost_full=0, wr_en=0 if wr=0. Reset mid-operation discards all contents; no register file clear is required.
- Implicit states, derived from level: EMPTY (0), PARTIAL (1..2**W-1), FULL (2**W).
- Accept rules, evaluated combinationally from the registered state:
  - push_ok = wr & (~full | rd)
  - pop_ok = rd & ~empty
- wr_en = push_ok & ~clr (combinational). w_addr = w_ptr and r_addr = r_ptr, both driven directly from registers.
- On each rising edge with rst=1:
  - clr=1 has priority over everything: w_ptr=0, r_ptr=0, level=0, overflow=0, underflow=0. Pushes and pops in the same cycle are discarded, with wr_en forced 0.
  - Otherwise, w_ptr += push_ok and r_ptr += pop_ok, modulo 2**W (natural wrap from 2**W-1 to 0).
  - level += push_ok - pop_ok. Simultaneous accepted push and pop leaves level unchanged.
  - overflow is set when wr & ~push_ok (push while FULL without a pop).
  - underflow is set when rd & ~pop_ok (pop while EMPTY). Both flags hold until clr or reset.
- Full with wr & rd: both are accepted. The write lands at w_ptr == r_ptr, and the old word is consumed combinationally in the same cycle. level stays 2**W.
- Empty with wr & rd: only the push is accepted. underflow is set, level becomes 1, and r_ptr is unchanged.
- FWFT latency: a word pushed at edge N is visible on register file r_data after edge N, with empty=0 in cycle N+1.
- full, empty, almost_full and almost_empty are combinational decodes of the level register, so they are glitch-free relative to clk and carry no input-to-output paths.
- No other combinational path exists from wr/rd to the status outputs. Only wr_en depends combinationally on wr, rd and clr.

Decomposition:
- Shared include uart_defs.vh: default FIFO address width (3) and the AF_TH/AE_TH defaults used by both the rx and tx FIFOs.
- No sub-module inside fifo_ctrl. The natural parent is uart_fifo, which instantiates the existing register file plus fifo_ctrl. The benches drive uart_fifo so the register file monitor can run alongside.

Test Plan (W=3, AF_TH=6, AE_TH=1):
- Reset then idle: rst=0 for 2 cycles, release -> level=0, empty=1, almost_empty=1, full=0, w_addr=r_addr=0, overflow=underflow=0.
- Push 8 words 0x11..0x18 -> level counts 1..8; almost_empty drops at level 2; almost_full rises at level 6; full=1 at 8; w_addr wraps to 0.
- Ninth push while full (wr only) -> wr_en=0, level stays 8, overflow=1 sticky; then pop 8 -> r_data reads 0x11..0x18 in order, empty=1, r_addr=0.
- Pop while empty (rd only) -> underflow=1, r_addr unchanged; wr&rd while empty -> level=1, underflow stays 1.
- Fill to 8, then wr&rd with data 0x99 for 3 cycles -> level stays 8, popped data 0x11,0x12,0x13, wr_en=1 each cycle, overflow=0.
- Fill to 5, assert clr together with wr -> next cycle level=0, pointers 0, flags cleared, wr_en=0 in the clr cycle. Separately, assert rst mid-burst -> outputs go to reset values asynchronously, before the next clock edge.
